// File: rtl/ntt_core_param.sv
// Purpose: Dilithium forward NTT / inverse NTT-to-mont engine, streaming coefficients in and out.
// Latency: after load, log2(N) layers of N/(2*LANES)+MUL_LAT cycles, plus N/LANES+MUL_LAT for inverse scale.
// Backpressure: in_ready only in LOAD, out_valid only in UNLOAD; out_data holds while out_ready is low.
module ntt_core_param #(
   parameter int N       = 256,
   parameter int W       = 32,
   parameter int LANES   = 8,
   parameter int MUL_LAT = 2,
   parameter int QINV    = 58728449,
   parameter int F       = 41978
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         mode,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         busy,
   output logic         done
);
   localparam int LOG         = $clog2(N);
   localparam int LW          = $clog2(LOG) + 1;
   localparam int CW          = $clog2(N + MUL_LAT) + 1;
   localparam int LAYER_ISSUE = N / (2 * LANES);
   localparam int SCALE_ISSUE = N / LANES;
   localparam longint Q_L     = 64'sd8380417;
   localparam logic signed [2*W-1:0] Q_WIDE = (2*W)'(Q_L);
   localparam logic [W-1:0] QINV_W = W'(QINV);
   localparam logic [W-1:0] F_W    = W'(F);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_LAYER  = 3'd2;
   localparam logic [2:0] S_SCALE  = 3'd3;
   localparam logic [2:0] S_UNLOAD = 3'd4;

   // One multiply slot: x is the pass-through operand, ma*mb goes through fqmul.
   typedef struct packed {
      logic           vld;
      logic [W-1:0]   x;
      logic [W-1:0]   ma;
      logic [W-1:0]   mb;
      logic [LOG-1:0] ilo;
      logic [LOG-1:0] ihi;
   } slot_t;

   function automatic int brv(input int v);
      int r;
      r = 0;
      for (int b = 0; b < LOG; b++)
         if (((v >> b) & 1) != 0) r = r | (1 << (LOG - 1 - b));
      return r;
   endfunction

   function automatic longint powmod(input longint base, input int e);
      longint acc;
      longint bb;
      acc = 1;
      bb  = base;
      for (int b = 0; b < 31; b++) begin
         if (((e >> b) & 1) != 0) acc = (acc * bb) % Q_L;
         bb = (bb * bb) % Q_L;
      end
      return acc;
   endfunction

   // Twiddle in Montgomery form, centred like the reference table: mont * root^brv(i) mod q.
   function automatic logic [W-1:0] zeta_of(input int i);
      longint root;
      longint z;
      root = powmod(64'sd1753, 256 / N);
      z    = (64'sd4193792 * powmod(root, brv(i))) % Q_L;
      if (z > Q_L / 2) z = z - Q_L;
      return z[W-1:0];
   endfunction

   // Montgomery product a*b*2^-W mod q, no final reduction.
   function automatic logic [W-1:0] fqmul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] p;
      logic signed [2*W-1:0] tq;
      logic signed [2*W-1:0] r;
      logic [W-1:0]          t;
      p  = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      t  = p[W-1:0] * QINV_W;
      tq = $signed({{W{t[W-1]}}, t}) * Q_WIDE;
      r  = p - tq;
      return r[2*W-1:W];
   endfunction

   logic [2:0]     state_q, state_d;
   logic           mode_q, mode_d;
   logic [LOG-1:0] idx_q, idx_d;
   logic [LW-1:0]  layer_q, layer_d;
   logic [CW-1:0]  cyc_q, cyc_d;
   logic           done_q, done_d;
   logic [W-1:0]   mem_q [N];
   logic [W-1:0]   mem_d [N];
   slot_t          pipe_q [MUL_LAT][LANES];
   slot_t          pipe_d [MUL_LAT][LANES];
   slot_t          iss [LANES];
   logic [W-1:0]   wb_prod [LANES];
   logic [W-1:0]   zeta_rom [N];
   int             sh, bi, grp, jl, jh, zi;

   for (genvar g = 0; g < N; g++) begin : g_zeta
      assign zeta_rom[g] = zeta_of(g);
   end

   assign busy      = (state_q != S_IDLE);
   assign in_ready  = (state_q == S_LOAD);
   assign out_valid = (state_q == S_UNLOAD);
   assign out_data  = out_valid ? mem_q[idx_q] : '0;
   assign done      = done_q;

   // Control FSM; start is ignored outside IDLE and in the done cycle.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      layer_d = layer_q;
      cyc_d   = cyc_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: if (start && !done_q) begin
            state_d = S_LOAD;
            mode_d  = mode;
            idx_d   = '0;
         end
         S_LOAD: if (in_valid) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LOG'(N - 1)) begin
               state_d = S_LAYER;
               layer_d = '0;
               cyc_d   = '0;
            end
         end
         S_LAYER: if (cyc_q == CW'(LAYER_ISSUE + MUL_LAT - 1)) begin
            cyc_d = '0;
            if (layer_q == LW'(LOG - 1)) state_d = mode_q ? S_SCALE : S_UNLOAD;
            else layer_d = layer_q + 1'b1;
         end else begin
            cyc_d = cyc_q + 1'b1;
         end
         S_SCALE: if (cyc_q == CW'(SCALE_ISSUE + MUL_LAT - 1)) begin
            state_d = S_UNLOAD;
            cyc_d   = '0;
         end else begin
            cyc_d = cyc_q + 1'b1;
         end
         S_UNLOAD: if (out_ready) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LOG'(N - 1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (reset) begin
         state_d = S_IDLE;
         mode_d  = 1'b0;
         idx_d   = '0;
         layer_d = '0;
         cyc_d   = '0;
         done_d  = 1'b0;
      end
   end

   // Issue: map (cycle, lane) to butterfly index, addresses and twiddle in reference order.
   always_comb begin
      sh = 0; bi = 0; grp = 0; jl = 0; jh = 0; zi = 0;
      for (int l = 0; l < LANES; l++) begin
         iss[l] = '0;
         if (state_q == S_LAYER && int'(cyc_q) < LAYER_ISSUE) begin
            sh  = mode_q ? int'(layer_q) : LOG - 1 - int'(layer_q);
            bi  = int'(cyc_q) * LANES + l;
            grp = bi >> sh;
            jl  = (grp << (sh + 1)) + (bi & ((1 << sh) - 1));
            jh  = jl + (1 << sh);
            iss[l].vld = 1'b1;
            iss[l].ilo = LOG'(jl);
            iss[l].ihi = LOG'(jh);
            if (!mode_q) begin
               zi = (N >> (sh + 1)) + grp;
               iss[l].x  = mem_q[LOG'(jl)];
               iss[l].ma = zeta_rom[LOG'(zi)];
               iss[l].mb = mem_q[LOG'(jh)];
            end else begin
               zi = (N >> sh) - 1 - grp;
               iss[l].x  = mem_q[LOG'(jl)] + mem_q[LOG'(jh)];
               iss[l].ma = -zeta_rom[LOG'(zi)];
               iss[l].mb = mem_q[LOG'(jl)] - mem_q[LOG'(jh)];
            end
         end else if (state_q == S_SCALE && int'(cyc_q) < SCALE_ISSUE) begin
            bi = int'(cyc_q) * LANES + l;
            iss[l].vld = 1'b1;
            iss[l].ilo = LOG'(bi);
            iss[l].ihi = LOG'(bi);
            iss[l].ma  = mem_q[LOG'(bi)];
            iss[l].mb  = F_W;
         end
      end
   end

   // Multiplier delay line; reset flushes in-flight products.
   always_comb begin
      pipe_d[0] = iss;
      for (int s = 1; s < MUL_LAT; s++) pipe_d[s] = pipe_q[s-1];
      if (reset)
         for (int s = 0; s < MUL_LAT; s++)
            for (int l = 0; l < LANES; l++) pipe_d[s][l] = '0;
   end

   // Montgomery product at the end of the delay line.
   always_comb begin
      for (int l = 0; l < LANES; l++)
         wb_prod[l] = fqmul(pipe_q[MUL_LAT-1][l].ma, pipe_q[MUL_LAT-1][l].mb);
   end

   // Coefficient RAM: load writes and butterfly/scale writeback; layers never overlap.
   always_comb begin
      mem_d = mem_q;
      if (state_q == S_LOAD && in_valid) mem_d[idx_q] = in_data;
      for (int l = 0; l < LANES; l++) begin
         if (pipe_q[MUL_LAT-1][l].vld) begin
            if (state_q == S_SCALE) begin
               mem_d[pipe_q[MUL_LAT-1][l].ihi] = wb_prod[l];
            end else if (!mode_q) begin
               mem_d[pipe_q[MUL_LAT-1][l].ilo] = pipe_q[MUL_LAT-1][l].x + wb_prod[l];
               mem_d[pipe_q[MUL_LAT-1][l].ihi] = pipe_q[MUL_LAT-1][l].x - wb_prod[l];
            end else begin
               mem_d[pipe_q[MUL_LAT-1][l].ilo] = pipe_q[MUL_LAT-1][l].x;
               mem_d[pipe_q[MUL_LAT-1][l].ihi] = wb_prod[l];
            end
         end
      end
      if (reset) for (int i = 0; i < N; i++) mem_d[i] = '0;
   end

   // State registers; reset is folded into the next-state logic.
   always_ff @(posedge clock) begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      layer_q <= layer_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
      pipe_q  <= pipe_d;
   end
endmodule
